// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl
// Description : Single-bit GPIO controller placed directly upstream of a
//               bidirectional PAD_cell. It registers the pad output value and
//               the direction controls, and inserts a one-cycle
//               break-before-make turnaround so that OE and IE are never high
//               together. On the input side it synchronises the pad Y pin,
//               can optionally debounce it, and produces edge pulses and a
//               sticky, maskable interrupt.
//
//   Ports:
//     clk          : system clock, rising edge
//     rst          : asynchronous active-high reset
//     dir          : requested direction (1 = output, 0 = input)
//     out_val      : value driven on the pad in output mode
//     in_en        : input enable request, honoured only in input mode
//     irq_rise_en  : interrupt on a rising edge of in_val
//     irq_fall_en  : interrupt on a falling edge of in_val
//     irq_clr      : clears the sticky interrupt
//     pad_y        : PAD_cell Y
//     pad_a        : PAD_cell A
//     pad_oe       : PAD_cell OE
//     pad_ie       : PAD_cell IE
//     in_val       : synchronised (and debounced when enabled) pad input
//     rise_evt     : one-cycle pulse on in_val 0->1
//     fall_evt     : one-cycle pulse on in_val 1->0
//     irq          : sticky interrupt
//
//   Build option : define GPIO_DEBOUNCE_EN to include the debounce counter.
//                  Without it, in_val follows the synchroniser output and
//                  DEBOUNCE_CNT / CNT_W have no effect.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl #(
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dir,
  input  logic out_val,
  input  logic in_en,
  input  logic irq_rise_en,
  input  logic irq_fall_en,
  input  logic irq_clr,
  input  logic pad_y,
  output logic pad_a,
  output logic pad_oe,
  output logic pad_ie,
  output logic in_val,
  output logic rise_evt,
  output logic fall_evt,
  output logic irq
);

  typedef enum logic [1:0] {
    S_IN   = 2'd0,
    S_TURN = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_pad_a;
  logic   r_pad_oe;
  logic   r_pad_ie;
  logic   r_s1;
  logic   r_s2;
  logic   r_in_val_d;
  logic   r_irq;
  logic   w_in_val;
  logic   w_irq_set;

  // Direction FSM. OE/IE are registered from the next state so that both
  // are already low for the whole S_TURN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IN;
      r_pad_oe <= 1'b0;
      r_pad_ie <= 1'b0;
    end else begin
      case (r_state)
        S_IN: begin
          r_pad_oe <= 1'b0;
          if (dir) begin
            r_state  <= S_TURN;
            r_pad_ie <= 1'b0;
          end else begin
            r_pad_ie <= in_en;
          end
        end
        S_TURN: begin
          if (dir) begin
            r_state  <= S_OUT;
            r_pad_oe <= 1'b1;
            r_pad_ie <= 1'b0;
          end else begin
            r_state  <= S_IN;
            r_pad_oe <= 1'b0;
            r_pad_ie <= in_en;
          end
        end
        S_OUT: begin
          r_pad_ie <= 1'b0;
          if (!dir) begin
            r_state  <= S_TURN;
            r_pad_oe <= 1'b0;
          end else begin
            r_pad_oe <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IN;
          r_pad_oe <= 1'b0;
          r_pad_ie <= 1'b0;
        end
      endcase
    end
  end

  // Output data register: follows out_val every cycle whatever the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_a <= 1'b0;
    end else begin
      r_pad_a <= out_val;
    end
  end

  // Two-flop synchroniser. It freezes while IE is low so a floating Y is
  // never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else if (r_pad_ie) begin
      r_s1 <= pad_y;
      r_s2 <= r_s1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_in_val;

  // in_val only takes the new level once s2 has disagreed with it for
  // DEBOUNCE_CNT consecutive enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_in_val <= 1'b0;
    end else if ((r_s2 == r_in_val) || !r_pad_ie) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_in_val <= r_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_in_val = r_in_val;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{DEBOUNCE_CNT[0], CNT_W[0]};
  assign w_in_val     = r_s2;
`endif

  // Edge detection and sticky interrupt; a new event wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_val_d <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_in_val_d <= w_in_val;
      r_irq      <= w_irq_set | (r_irq & ~irq_clr);
    end
  end

  assign rise_evt  = w_in_val & ~r_in_val_d;
  assign fall_evt  = ~w_in_val & r_in_val_d;
  assign w_irq_set = (rise_evt & irq_rise_en) | (fall_evt & irq_fall_en);

  assign pad_a  = r_pad_a;
  assign pad_oe = r_pad_oe;
  assign pad_ie = r_pad_ie;
  assign in_val = w_in_val;
  assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pad_ctrl
// Description : Self-checking bench for gpio_pad_ctrl. A direction table,
//               hand-written input/interrupt/reset sequences and a random
//               phase, all compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_ctrl;

  localparam int DEB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT    = DEB + 2;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dir = 1'b0, out_val = 1'b0, in_en = 1'b0;
  logic irq_rise_en = 1'b0, irq_fall_en = 1'b0, irq_clr = 1'b0, pad_y = 1'b0;
  logic pad_a, pad_oe, pad_ie, in_val, rise_evt, fall_evt, irq;

  int checks   = 0;
  int failures = 0;

  gpio_pad_ctrl #(.DEBOUNCE_CNT(DEB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dir(dir), .out_val(out_val), .in_en(in_en),
    .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .irq_clr(irq_clr),
    .pad_y(pad_y), .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie),
    .in_val(in_val), .rise_evt(rise_evt), .fall_evt(fall_evt), .irq(irq)
  );

  always #5 clk = ~clk;

  // OE and IE high together would short the pad; watch it every cycle.
  always @(negedge clk) begin
    checks++;
    if (pad_oe === 1'b1 && pad_ie === 1'b1) begin
      failures++;
      $display("FAIL oe_ie_overlap actual=11 required=not both 1 t=%0t", $time);
    end
  end

  // ---------------- reference model ----------------
  // Direction: a settled side plus a "turning" flag; the pad may only be
  // driven/enabled when settled. Input: a 2-deep sampled delay line, then
  // (optionally) a flip once DEB consecutive disagreeing samples are seen.
  bit m_side, m_turn, m_oe, m_ie, m_a, m_s1, m_s2, m_in, m_in_d, m_irq;
  bit dis_q[$];

  function automatic void model_reset();
    m_side = 0; m_turn = 0; m_oe = 0; m_ie = 0; m_a = 0;
    m_s1 = 0; m_s2 = 0; m_in = 0; m_in_d = 0; m_irq = 0;
    dis_q.delete();
  endfunction

  function automatic void model_edge();
    bit ie_old, in_old, s2_old, ev;
    int ones;
    ie_old = m_ie; in_old = m_in; s2_old = m_s2;
    ev = ((m_in && !m_in_d) && irq_rise_en) || ((!m_in && m_in_d) && irq_fall_en);
    m_irq  = ev || (m_irq && !irq_clr);
    m_in_d = in_old;
    if (ie_old) begin
      m_s2 = m_s1;
      m_s1 = pad_y;
    end
    if (DEB_ON) begin
      dis_q.push_back(ie_old && (s2_old != in_old));
      if (dis_q.size() > DEB) void'(dis_q.pop_front());
      ones = 0;
      foreach (dis_q[k]) ones += int'(dis_q[k]);
      if (ones == DEB) begin
        m_in = ~in_old;
        dis_q.delete();
      end
    end else begin
      m_in = m_s2;
    end
    if (m_turn) begin
      m_turn = 0;
      m_side = dir;
    end else if (dir != m_side) begin
      m_turn = 1;
    end
    m_oe = !m_turn && m_side;
    m_ie = !m_turn && !m_side && in_en;
    m_a  = out_val;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".pad_a"},    pad_a,    m_a);
    chk({tag, ".pad_oe"},   pad_oe,   m_oe);
    chk({tag, ".pad_ie"},   pad_ie,   m_ie);
    chk({tag, ".in_val"},   in_val,   m_in);
    chk({tag, ".rise_evt"}, rise_evt, m_in && !m_in_d);
    chk({tag, ".fall_evt"}, fall_evt, !m_in && m_in_d);
    chk({tag, ".irq"},      irq,      m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step_cmp(input string tag);
    step();
    cmp_all(tag);
  endtask

  typedef struct {
    bit dir, out_val, in_en;
    bit e_a, e_oe, e_ie;
  } vec_t;

  vec_t tbl[14];

  initial begin
    //            dir out en   a  oe ie
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // ---- reset state ----
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // ---- direction table ----
    foreach (tbl[i]) begin
      dir = tbl[i].dir; out_val = tbl[i].out_val; in_en = tbl[i].in_en;
      step();
      chk($sformatf("tbl%0d.pad_a", i),  pad_a,  tbl[i].e_a);
      chk($sformatf("tbl%0d.pad_oe", i), pad_oe, tbl[i].e_oe);
      chk($sformatf("tbl%0d.pad_ie", i), pad_ie, tbl[i].e_ie);
      cmp_all($sformatf("tbl%0d", i));
    end

    // ---- back to input mode, pad low ----
    dir = 1'b0; in_en = 1'b1; pad_y = 1'b0; irq_rise_en = 1'b1;
    repeat (4) step_cmp("settle_in");
    chk("settle_in.pad_ie", pad_ie, 1'b1);

`ifdef GPIO_DEBOUNCE_EN
    // Glitch shorter than the debounce window must be rejected.
    pad_y = 1'b1;
    repeat (DEB - 1) step_cmp("glitch_hi");
    pad_y = 1'b0;
    repeat (LAT + 4) begin
      step_cmp("glitch_lo");
      chk("glitch.in_val", in_val, 1'b0);
      chk("glitch.rise_evt", rise_evt, 1'b0);
      chk("glitch.irq", irq, 1'b0);
    end
`else
    // A single-cycle pulse passes straight through the synchroniser.
    pad_y = 1'b1;
    step_cmp("pulse1");
    pad_y = 1'b0;
    step_cmp("pulse2");
    chk("pulse2.in_val", in_val, 1'b1);
    chk("pulse2.rise_evt", rise_evt, 1'b1);
    step_cmp("pulse3");
    chk("pulse3.in_val", in_val, 1'b0);
    chk("pulse3.rise_evt", rise_evt, 1'b0);
    chk("pulse3.irq", irq, 1'b1);
    repeat (3) step_cmp("pulse_tail");
`endif
    irq_clr = 1'b1;
    step_cmp("pre_clr");
    irq_clr = 1'b0;
    step_cmp("pre_clr2");
    chk("pre_clr.irq", irq, 1'b0);

    // ---- input latency and rising interrupt ----
    pad_y = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      step_cmp($sformatf("lat_e%0d", e));
      if (e == LAT - 1) chk("lat.in_val_early", in_val, 1'b0);
      if (e == LAT) begin
        chk("lat.in_val", in_val, 1'b1);
        chk("lat.rise_evt", rise_evt, 1'b1);
      end
      if (e == LAT + 1) begin
        chk("lat.rise_once", rise_evt, 1'b0);
        chk("lat.irq", irq, 1'b1);
      end
    end

    // ---- interrupt clear / set priority ----
    irq_clr = 1'b1;
    step_cmp("clr_alone");
    chk("clr_alone.irq", irq, 1'b0);
    irq_clr = 1'b0; irq_fall_en = 1'b1; pad_y = 1'b0;
    for (int e = 1; e <= LAT; e++) step_cmp($sformatf("fall_e%0d", e));
    chk("fall.fall_evt", fall_evt, 1'b1);
    irq_clr = 1'b1;
    step_cmp("set_vs_clr");
    chk("set_vs_clr.irq", irq, 1'b1);
    irq_clr = 1'b0; irq_rise_en = 1'b0; irq_fall_en = 1'b0;
    step_cmp("en_change");
    chk("en_change.irq", irq, 1'b1);
    irq_clr = 1'b1;
    step_cmp("clr_later");
    chk("clr_later.irq", irq, 1'b0);
    irq_clr = 1'b0;

    // ---- randomized phase ----
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 6) == 0) pad_y = ~pad_y;
      if ($urandom_range(0, 9) == 0) irq_rise_en = 1'($urandom);
      if ($urandom_range(0, 9) == 0) irq_fall_en = 1'($urandom);
      in_en   = ($urandom_range(0, 7) != 0);
      out_val = 1'($urandom);
      irq_clr = ($urandom_range(0, 9) == 0);
      step_cmp("rand");
    end

    // ---- asynchronous reset while driving in S_OUT ----
    dir = 1'b0; in_en = 1'b1; pad_y = 1'b0; irq_clr = 1'b0;
    irq_rise_en = 1'b1; irq_fall_en = 1'b0;
    repeat (20) step_cmp("rst_prep_lo");
    irq_clr = 1'b1;
    step_cmp("rst_prep_clr");
    irq_clr = 1'b0;
    pad_y = 1'b1;
    repeat (LAT + 3) step_cmp("rst_prep_hi");
    dir = 1'b1; out_val = 1'b1;
    repeat (4) step_cmp("rst_prep_out");
    chk("rst_pre.pad_oe", pad_oe, 1'b1);
    chk("rst_pre.pad_a", pad_a, 1'b1);
    chk("rst_pre.in_val", in_val, 1'b1);
    chk("rst_pre.irq", irq, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async.pad_oe", pad_oe, 1'b0);
    chk("rst_async.pad_ie", pad_ie, 1'b0);
    chk("rst_async.pad_a", pad_a, 1'b0);
    chk("rst_async.in_val", in_val, 1'b0);
    chk("rst_async.rise_evt", rise_evt, 1'b0);
    chk("rst_async.fall_evt", fall_evt, 1'b0);
    chk("rst_async.irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dir = 1'b0;
    repeat (6) step_cmp("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
